spi_burst_memory: RTL

SPI_BURST_MEMORY -- requirements
Module: spi_burst_memory

---
 rtl/spi_burst_memory.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/spi_burst_memory.sv
// SPI mode-0 slave fronting a burst-addressed word memory.
// All pins are synchronized into clk; header = address (MSB first) then rw bit.
module spi_burst_memory #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk_pin,
  input  logic       cs_pin,
  input  logic       mosi_pin,
  output logic       miso_pin,
  output logic [3:0] leds
);
  localparam int CNT_W = 6;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE, HEADER, WRITE_DATA, READ_LOAD, READ_DATA
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic [2:0]             flush_q;
  logic                   armed_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   hdr_q, hdr_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                abort_q, abort_d;
  logic                wr_stb;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '1;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b1;
      flush_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_pin};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_pin};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_pin};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
      // After reset the chain holds its reset value, not the pin; only accept a
      // cs fall once the real pin has been seen high, so a transaction cut by
      // reset cannot be resumed without a genuine new cs falling edge.
      if (flush_q != 3'(SYNC_STAGES + 1)) flush_q <= flush_q + 3'd1;
      else if (cs_s)                       armed_q <= 1'b1;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q & ~cs_s;
  assign sclk_fall = ~sclk_s & sclk_prev_q & ~cs_s;
  assign cs_fall   = ~cs_s & cs_prev_q & armed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      hdr_q   <= '0;
      shreg_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      hdr_q   <= hdr_d;
      shreg_q <= shreg_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    hdr_d   = hdr_q;
    shreg_d = shreg_q;
    abort_d = abort_q;
    wr_stb  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = HEADER;
          cnt_d   = '0;
          abort_d = 1'b0;
        end
      end
      HEADER: begin
        if (sclk_rise) begin
          hdr_d = {hdr_q[ADDR_W-2:0], mosi_s};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ADDR_W)) begin
            addr_d  = hdr_q;
            cnt_d   = '0;
            state_d = mosi_s ? READ_LOAD : WRITE_DATA;
          end
        end
      end
      WRITE_DATA: begin
        if (cnt_q == CNT_W'(DATA_W)) begin
          wr_stb = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = '0;
        end else if (sclk_rise) begin
          shreg_d = {shreg_q[DATA_W-2:0], mosi_s};
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      READ_LOAD: begin
        if (sclk_fall) begin
          shreg_d = mem_q[addr_q];
          state_d = READ_DATA;
        end
      end
      READ_DATA: begin
        if (sclk_fall) shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
        if (sclk_rise) begin
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            addr_d  = addr_q + ADDR_W'(1);
            cnt_d   = '0;
            state_d = READ_LOAD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A completed word still commits even if cs rises in the strobe cycle.
    if (state_q != IDLE && cs_s) begin
      state_d = IDLE;
      cnt_d   = '0;
      if (cnt_q != '0 && !wr_stb) abort_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_stb) mem_q[addr_q] <= shreg_q;
  end

  assign miso_pin = (state_q == READ_DATA && !cs_s) ? shreg_q[DATA_W-1] : 1'bz;
  assign leds     = {abort_q, wr_stb,
                     (state_q == READ_LOAD) || (state_q == READ_DATA),
                     state_q != IDLE};
endmodule
